// File: rtl/alu_md_control.sv
// alu_md_control
// EX-stage ALU control with an attached iterative multiply/divide unit.
// - Decodes ALUOp/Funct into the 5-bit ALU function code and the Sign flag.
// - Owns the architectural HI/LO registers. MULT/MULTU run as a radix-2
//   shift-add. DIV/DIVU run as a restoring divider. Each takes WIDTH
//   iterations plus one fix-up cycle.
// - Raises stall while the unit is busy and another MD op sits in EX.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ALUOp, Funct        main-control opcode and instruction funct field
//   valid               EX instruction is real (not a bubble)
//   op_a, op_b          forwarded rs / rt operands
//   ALUCtl, Sign        ALU function code and signed-compare flag
//   md_sel, md_rdata    EX result comes from HI/LO (MFHI/MFLO) and its value
//   md_busy, stall      MDU iterating; pipeline hold request
//   hi, lo              architectural HI/LO registers
module alu_md_control #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [4:0]       ALUCtl,
    output logic             Sign,
    output logic             md_sel,
    output logic [WIDTH-1:0] md_rdata,
    output logic             md_busy,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_MUL  = 2'b01;
    localparam logic [1:0] ST_DIV  = 2'b10;
    localparam logic [1:0] ST_FIX  = 2'b11;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             op_div_r;
    logic             neg_q_r;    // quotient / product must be negated
    logic             neg_r_r;    // remainder takes the dividend's sign
    logic             dz_r;       // divide by zero
    logic [WIDTH-1:0] acc_r;      // product high half / partial remainder
    logic [WIDTH-1:0] quo_r;      // product low half / dividend-quotient
    logic [WIDTH-1:0] b_r;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             alu_funct_s;
    logic             md_code_s;
    logic             is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s, is_mul_s, is_div_s;
    logic [4:0]       alu_ctl_s;
    logic             sign_s;
    logic             accept_s;
    logic             a_neg_s, b_neg_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic             div_ok_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    assign alu_funct_s = (ALUOp[2:0] == 3'b010);

    // Classify the funct field into the multiply/divide operations.
    always_comb begin
        is_mfhi_s = 1'b0;
        is_mflo_s = 1'b0;
        is_mthi_s = 1'b0;
        is_mtlo_s = 1'b0;
        is_mul_s  = 1'b0;
        is_div_s  = 1'b0;
        md_code_s = 1'b1;
        case (Funct)
            F_MFHI:           is_mfhi_s = 1'b1;
            F_MFLO:           is_mflo_s = 1'b1;
            F_MTHI:           is_mthi_s = 1'b1;
            F_MTLO:           is_mtlo_s = 1'b1;
            F_MULT, F_MULTU:  is_mul_s  = 1'b1;
            F_DIV, F_DIVU:    is_div_s  = 1'b1;
            default:          md_code_s = 1'b0;
        endcase
    end

    // ALU function code and Sign decode; MD ops read as ADD/signed.
    always_comb begin
        alu_ctl_s = ALU_ADD;
        case (ALUOp[2:0])
            3'b000: alu_ctl_s = ALU_ADD;
            3'b001: alu_ctl_s = ALU_SUB;
            3'b100: alu_ctl_s = ALU_AND;
            3'b101: alu_ctl_s = ALU_SLT;
            3'b010: begin
                casez (Funct)
                    6'b000000: alu_ctl_s = ALU_SLL;
                    6'b000010: alu_ctl_s = ALU_SRL;
                    6'b000011: alu_ctl_s = ALU_SRA;
                    6'b10000?: alu_ctl_s = ALU_ADD;
                    6'b10001?: alu_ctl_s = ALU_SUB;
                    6'b100100: alu_ctl_s = ALU_AND;
                    6'b100101: alu_ctl_s = ALU_OR;
                    6'b100110: alu_ctl_s = ALU_XOR;
                    6'b100111: alu_ctl_s = ALU_NOR;
                    6'b10101?: alu_ctl_s = ALU_SLT;
                    default:   alu_ctl_s = ALU_ADD;
                endcase
            end
            default: alu_ctl_s = ALU_ADD;
        endcase
        if (alu_funct_s) begin
            sign_s = md_code_s ? 1'b1 : ~Funct[0];
        end else begin
            sign_s = ~ALUOp[3];
        end
    end

    assign ALUCtl   = alu_ctl_s;
    assign Sign     = sign_s;
    assign md_sel   = valid & alu_funct_s & (is_mfhi_s | is_mflo_s);
    assign md_rdata = is_mflo_s ? lo_r : hi_r;
    assign md_busy  = busy_r;
    assign stall    = valid & alu_funct_s & md_code_s & busy_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

    // An MD op in EX is taken only when the unit is idle; otherwise it stalls.
    assign accept_s = valid & alu_funct_s & md_code_s & ~busy_r;

    // Operand magnitudes: MULT/DIV (Funct[0]=0) are signed.
    always_comb begin
        a_neg_s = ~Funct[0] & op_a[WIDTH-1];
        b_neg_s = ~Funct[0] & op_b[WIDTH-1];
        a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - op_a) : op_a;
        b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - op_b) : op_b;
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (quo_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r, quo_r[WIDTH-1]};
        div_ok_s    = (div_shift_s >= {1'b0, b_r});
        // The difference is below the divisor, so WIDTH bits always hold it.
        div_rem_s   = div_shift_s[WIDTH-1:0] - b_r;
    end

    // Sign fix-up of the magnitude results; divide-by-zero forces LO to ones.
    always_comb begin
        prod_fix_s = neg_q_r ? ({(2*WIDTH){1'b0}} - {acc_r, quo_r}) : {acc_r, quo_r};
        if (dz_r) begin
            quo_fix_s = {WIDTH{1'b1}};
        end else begin
            quo_fix_s = neg_q_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
        end
        // With a zero divisor the remainder is the dividend magnitude, so this
        // also restores op_a for the divide-by-zero HI value.
        rem_fix_s = neg_r_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;
    end

    // MDU sequencer, iteration datapath and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            busy_r   <= 1'b0;
            op_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            dz_r     <= 1'b0;
            acc_r    <= {WIDTH{1'b0}};
            quo_r    <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (is_mul_s || is_div_s)) begin
                        acc_r    <= {WIDTH{1'b0}};
                        quo_r    <= a_mag_s;
                        b_r      <= b_mag_s;
                        neg_q_r  <= a_neg_s ^ b_neg_s;
                        neg_r_r  <= a_neg_s;
                        dz_r     <= (op_b == {WIDTH{1'b0}});
                        op_div_r <= is_div_s;
                        cnt_r    <= CW'(WIDTH - 1);
                        busy_r   <= 1'b1;
                        state_r  <= is_div_s ? ST_DIV : ST_MUL;
                    end else if (accept_s && is_mthi_s) begin
                        hi_r <= op_a;
                    end else if (accept_s && is_mtlo_s) begin
                        lo_r <= op_a;
                    end
                end
                ST_MUL: begin
                    acc_r <= mul_sum_s[WIDTH:1];
                    quo_r <= {mul_sum_s[0], quo_r[WIDTH-1:1]};
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_DIV: begin
                    acc_r <= div_ok_s ? div_rem_s : div_shift_s[WIDTH-1:0];
                    quo_r <= {quo_r[WIDTH-2:0], div_ok_s};
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIX: begin
                    if (op_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_control.sv
module tb_alu_md_control;
    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ALUOp;
    logic [5:0]   Funct;
    logic         valid;
    logic [W-1:0] op_a, op_b;
    logic [4:0]   ALUCtl;
    logic         Sign;
    logic         md_sel;
    logic [W-1:0] md_rdata;
    logic         md_busy;
    logic         stall;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    alu_md_control #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Funct(Funct), .valid(valid),
        .op_a(op_a), .op_b(op_b), .ALUCtl(ALUCtl), .Sign(Sign), .md_sel(md_sel),
        .md_rdata(md_rdata), .md_busy(md_busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish before 400000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_md(input logic [5:0] f);
        return (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU});
    endfunction

    // Expected ALU code, written from the opcode/funct mnemonic table.
    function automatic logic [4:0] exp_ctl(input logic [3:0] aop, input logic [5:0] f);
        logic [2:0] op3;
        op3 = aop[2:0];
        if (op3 == 3'b001) return 5'b00110;
        if (op3 == 3'b100) return 5'b00000;
        if (op3 == 3'b101) return 5'b00111;
        if (op3 != 3'b010) return 5'b00010;
        if (f == 6'd0)  return 5'b10000;
        if (f == 6'd2)  return 5'b11000;
        if (f == 6'd3)  return 5'b11001;
        if (f == 6'd34 || f == 6'd35) return 5'b00110;
        if (f == 6'd36) return 5'b00000;
        if (f == 6'd37) return 5'b00001;
        if (f == 6'd38) return 5'b01101;
        if (f == 6'd39) return 5'b01100;
        if (f == 6'd42 || f == 6'd43) return 5'b00111;
        return 5'b00010;
    endfunction

    // Arithmetic reference for HI/LO after a multiply or divide.
    task automatic model_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        if (f == F_MULT) begin
            p = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (f == F_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b == 32'd0) begin
            exp_lo = 32'hFFFFFFFF;
            exp_hi = a;
        end else if (f == F_DIV) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                exp_lo = 32'h80000000;
                exp_hi = 32'd0;
            end else begin
                q = ia / ib;
                r = ia % ib;
                exp_lo = q;
                exp_hi = r;
            end
        end else begin
            exp_lo = a / b;
            exp_hi = a % b;
        end
    endtask

    // Present one MD op for a single cycle; returns just after its acceptance edge.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp = 4'b0010;
        Funct = f;
        valid = 1'b1;
        op_a  = a;
        op_b  = b;
        tick();
        valid = 1'b0;
        ALUOp = 4'b0000;
        Funct = 6'd0;
    endtask

    // Full MULT/DIV transaction with non-MD noise and operand churn while busy.
    task automatic run_md(input string tag, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        int cnt;
        model_md(f, a, b);
        issue(f, a, b);
        cnt = 0;
        while (md_busy && cnt < 100) begin
            valid = 1'($urandom_range(0, 1));
            ALUOp = 4'($urandom_range(0, 15));
            if (ALUOp[2:0] == 3'b010) ALUOp[2:0] = 3'b000;
            Funct = 6'($urandom_range(0, 63));
            op_a  = $urandom;
            op_b  = $urandom;
            #1;
            check({tag, "_nonmd_stall"}, {63'd0, stall}, 64'd0);
            cnt++;
            tick();
        end
        valid = 1'b0;
        ALUOp = 4'b0000;
        Funct = 6'd0;
        check({tag, "_busy_cycles"}, 64'(cnt), 64'(W + 1));
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    endtask

    initial begin
        int cnt;
        logic [5:0] fsel [4];
        logic [W-1:0] edges [6];
        logic [W-1:0] ra, rb;
        fsel  = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
        edges = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

        // Reset with an MD op pending: nothing may start, registers clear.
        reset = 1'b1;
        valid = 1'b1;
        ALUOp = 4'b0010;
        Funct = F_MULT;
        op_a  = 32'd5;
        op_b  = 32'd6;
        tick();
        tick();
        check("rst_hi", {32'd0, hi}, 64'd0);
        check("rst_lo", {32'd0, lo}, 64'd0);
        check("rst_busy", {63'd0, md_busy}, 64'd0);
        check("rst_stall", {63'd0, stall}, 64'd0);
        valid = 1'b0;
        reset = 1'b0;
        tick();
        check("rst_release_busy", {63'd0, md_busy}, 64'd0);

        // Decode sweep across every ALUOp/Funct pair (valid low).
        for (int a = 0; a < 16; a++) begin
            for (int f = 0; f < 64; f++) begin
                ALUOp = 4'(a);
                Funct = 6'(f);
                #1;
                check("dec_ctl", {59'd0, ALUCtl}, {59'd0, exp_ctl(4'(a), 6'(f))});
                if (!(ALUOp[2:0] == 3'b010 && is_md(6'(f)))) begin
                    check("dec_sign", {63'd0, Sign},
                          {63'd0, (ALUOp[2:0] == 3'b010) ? ~Funct[0] : ~ALUOp[3]});
                end
                check("dec_mdsel_bubble", {63'd0, md_sel}, 64'd0);
            end
        end
        ALUOp = 4'b0010;
        Funct = 6'b101011;
        #1;
        check("dec_sltu_ctl", {59'd0, ALUCtl}, 64'h07);
        check("dec_sltu_sign", {63'd0, Sign}, 64'd0);
        ALUOp = 4'b1000;
        #1;
        check("dec_op1000_ctl", {59'd0, ALUCtl}, 64'h02);
        check("dec_op1000_sign", {63'd0, Sign}, 64'd0);
        ALUOp = 4'b0000;
        Funct = 6'd0;

        // Directed multiply/divide cases with literal results.
        run_md("mult_m3x7", F_MULT, 32'hFFFFFFFD, 32'd7);
        check("mult_m3x7_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        run_md("multu_max2", F_MULTU, 32'hFFFFFFFF, 32'd2);
        check("multu_max2_lit", {hi, lo}, 64'h00000001_FFFFFFFE);
        run_md("div_m7d2", F_DIV, 32'hFFFFFFF9, 32'd2);
        check("div_m7d2_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        run_md("divu_7d0", F_DIVU, 32'd7, 32'd0);
        check("divu_7d0_lit", {hi, lo}, 64'h00000007_FFFFFFFF);
        run_md("div_m7d0", F_DIV, 32'hFFFFFFF9, 32'd0);
        check("div_m7d0_lit", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
        run_md("div_min_m1", F_DIV, 32'h80000000, 32'hFFFFFFFF);
        check("div_min_m1_lit", {hi, lo}, 64'h00000000_80000000);

        // MFLO waiting behind a MULT: stalls, then reads the new LO at once.
        model_md(F_MULT, 32'd5, 32'd9);
        issue(F_MULT, 32'd5, 32'd9);
        tick();
        ALUOp = 4'b0010;
        Funct = F_MFLO;
        valid = 1'b1;
        #1;
        cnt = 0;
        while (stall && cnt < 100) begin
            cnt++;
            tick();
        end
        check("mflo_stall_cycles", 64'(cnt), 64'd32);
        check("mflo_busy_after", {63'd0, md_busy}, 64'd0);
        check("mflo_sel", {63'd0, md_sel}, 64'd1);
        check("mflo_rdata", {32'd0, md_rdata}, {32'd0, exp_lo});
        check("mflo_rdata_lit", {32'd0, md_rdata}, 64'd45);
        tick();
        valid = 1'b0;

        // MTHI then MFHI back to back; MTLO then MFLO.
        issue(F_MTHI, 32'h1234, 32'd0);
        exp_hi = 32'h1234;
        ALUOp = 4'b0010;
        Funct = F_MFHI;
        valid = 1'b1;
        #1;
        check("mfhi_stall", {63'd0, stall}, 64'd0);
        check("mfhi_sel", {63'd0, md_sel}, 64'd1);
        check("mfhi_rdata", {32'd0, md_rdata}, 64'h1234);
        check("mthi_hi", {32'd0, hi}, {32'd0, exp_hi});
        issue(F_MTLO, 32'hCAFE0001, 32'd0);
        exp_lo = 32'hCAFE0001;
        ALUOp = 4'b0010;
        Funct = F_MFLO;
        valid = 1'b1;
        #1;
        check("mflo2_rdata", {32'd0, md_rdata}, {32'd0, exp_lo});
        check("mtlo_hi_kept", {32'd0, hi}, 64'h1234);
        valid = 1'b0;
        tick();

        // Reset during DIV iteration 10 aborts it; the next MULT is clean.
        issue(F_DIV, 32'd1000, 32'd7);
        repeat (10) tick();
        check("abort_busy_before", {63'd0, md_busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", {63'd0, md_busy}, 64'd0);
        check("abort_hi", {32'd0, hi}, 64'd0);
        check("abort_lo", {32'd0, lo}, 64'd0);
        run_md("mult_2x3", F_MULT, 32'd2, 32'd3);
        check("mult_2x3_lit", {32'd0, lo}, 64'd6);

        // Randomized MD ops, biased toward boundary operands.
        for (int i = 0; i < 24; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(1, 30);
            run_md("rand", fsel[$urandom_range(0, 3)], ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
